// File: rtl/ysyx_24070003_axil_pkg.sv
// Shared types and encodings for the AXI-Lite load initiator and its helpers.
package ysyx_24070003_axil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } axil_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Size code 3 has no legal encoding, so it is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b1;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_24070003_load_align.sv
// Byte-lane shift plus sign/zero extension of a read data word.
// Also meant to serve the cache refill path, so it stays purely combinational.
module ysyx_24070003_load_align
  import ysyx_24070003_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  // Pick the addressed lane and extend it to the full word.
  always_comb begin
    data_o = shifted;
    case (size_i)
      SZ_B:    data_o = {{(DATA_WIDTH-8){signed_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{(DATA_WIDTH-16){signed_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_24070003_axil_rd_master.sv
// AXI-Lite read initiator for the LSU load path: one outstanding read,
// misaligned requests answered locally without touching the bus.
module ysyx_24070003_axil_rd_master
  import ysyx_24070003_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] AXI4_M_ARADDR,
  output logic                  AXI4_M_ARVALID,
  input  logic                  AXI4_M_ARREADY,
  input  logic [DATA_WIDTH-1:0] AXI4_M_RDATA,
  input  logic [1:0]            AXI4_M_RRESP,
  input  logic                  AXI4_M_RVALID,
  output logic                  AXI4_M_RREADY
);

  axil_state_e           state_q;
  logic                  req_ready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [1:0]            addr_lo_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] load_data_d;

  ysyx_24070003_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .rdata_i   (AXI4_M_RDATA),
    .addr_lo_i (addr_lo_q),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .data_o    (load_data_d)
  );

  // Request/AR/R/response sequencing; every output is a register so no req_* input reaches the bus combinationally.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      araddr_q     <= '0;
      resp_data_q  <= '0;
      addr_lo_q    <= 2'b00;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_lo_q   <= req_addr[1:0];
            size_q      <= req_size;
            signed_q    <= req_signed;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              state_q   <= ST_AR;
              arvalid_q <= 1'b1;
              araddr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_AR: begin
          if (AXI4_M_ARREADY) begin
            state_q   <= ST_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_R: begin
          if (AXI4_M_RVALID) begin
            state_q      <= ST_RESP;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_data_d;
            resp_err_q   <= (AXI4_M_RRESP != OKAY);
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_err       = resp_err_q;
  assign AXI4_M_ARADDR  = araddr_q;
  assign AXI4_M_ARVALID = arvalid_q;
  assign AXI4_M_RREADY  = rready_q;

endmodule

// File: tb/tb_ysyx_24070003_axil_rd_master.sv
// Directed and randomized load transactions against a bench-side AXI-Lite slave,
// with expected data and timing computed from the load rules.
module tb_ysyx_24070003_axil_rd_master;

  logic        clock = 1'b0;
  logic        rstn  = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] AXI4_M_ARADDR;
  logic        AXI4_M_ARVALID;
  logic        AXI4_M_ARREADY;
  logic [31:0] AXI4_M_RDATA;
  logic [1:0]  AXI4_M_RRESP;
  logic        AXI4_M_RVALID;
  logic        AXI4_M_RREADY;

  int checks = 0;
  int errors = 0;

  ysyx_24070003_axil_rd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clock          (clock),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .AXI4_M_ARADDR  (AXI4_M_ARADDR),
    .AXI4_M_ARVALID (AXI4_M_ARVALID),
    .AXI4_M_ARREADY (AXI4_M_ARREADY),
    .AXI4_M_RDATA   (AXI4_M_RDATA),
    .AXI4_M_RRESP   (AXI4_M_RRESP),
    .AXI4_M_RVALID  (AXI4_M_RVALID),
    .AXI4_M_RREADY  (AXI4_M_RREADY)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Reference: does this size/address pair violate natural alignment?
  function automatic bit refMisaligned(input logic [31:0] addr, input int size);
    if (size == 0) return 1'b0;
    if (size == 1) return (addr % 2) != 0;
    if (size == 2) return (addr % 4) != 0;
    return 1'b1;
  endfunction

  // Reference: extract the addressed lane and extend it, using plain integer arithmetic.
  function automatic logic [31:0] refData(input logic [31:0] rdata, input logic [31:0] addr,
                                          input int size, input bit sgn);
    int unsigned lane;
    int unsigned v;
    int          s;
    lane = rdata / (32'd1 << (8 * (addr % 4)));
    if (size == 0) begin
      v = lane % 256;
      s = int'(v);
      if (sgn && v >= 128) s = s - 256;
      return 32'(s);
    end
    if (size == 1) begin
      v = lane % 65536;
      s = int'(v);
      if (sgn && v >= 32768) s = s - 65536;
      return 32'(s);
    end
    return lane;
  endfunction

  // One comparison: count it, and report it on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Advance to the sampling point just after the next rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the master to offer req_ready.
  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      nextCycle();
      n++;
    end
    if (req_ready !== 1'b1) checkOutput({tag, ".readyTimeout"}, {31'd0, req_ready}, 32'd1);
  endtask

  // One full load: request, slave with given AR/R wait cycles, per-cycle handshake and result checks.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [1:0] size,
                               input bit sgn, input logic [31:0] rdata, input logic [1:0] rresp,
                               input int arDelay, input int rDelay, input bit early);
    bit          mis;
    int          e;
    logic [31:0] expData;
    logic [31:0] expVec;
    logic [31:0] obsVec;
    logic        expErr;
    waitReady(tag);
    mis     = refMisaligned(addr, int'(size));
    e       = mis ? 1 : 3 + arDelay + rDelay;
    expData = mis ? 32'd0 : refData(rdata, addr, int'(size), sgn);
    expErr  = mis || (rresp != 2'd0);

    req_valid      = 1'b1;
    req_addr       = addr;
    req_size       = size;
    req_signed     = sgn;
    AXI4_M_ARREADY = 1'b0;
    AXI4_M_RVALID  = early;
    AXI4_M_RDATA   = ~rdata;
    AXI4_M_RRESP   = 2'd3;
    nextCycle();
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_size   = 2'($urandom_range(0, 3));
    req_signed = ~sgn;

    for (int c = 1; c <= e + 2; c++) begin
      expVec = {28'd0,
                (c > e),
                (!mis && c <= 1 + arDelay),
                (!mis && c >= 2 + arDelay && c <= 2 + arDelay + rDelay),
                (c == e)};
      obsVec = {28'd0, req_ready, AXI4_M_ARVALID, AXI4_M_RREADY, resp_valid};
      checkOutput($sformatf("%s.handshake.c%0d", tag, c), obsVec, expVec);
      if (!mis && c <= 1 + arDelay)
        checkOutput($sformatf("%s.araddr.c%0d", tag, c), AXI4_M_ARADDR, {addr[31:2], 2'b00});
      if (c == e) begin
        checkOutput({tag, ".data"}, resp_data, expData);
        checkOutput({tag, ".err"}, {31'd0, resp_err}, {31'd0, expErr});
      end
      AXI4_M_ARREADY = !mis && (c == 1 + arDelay);
      if (!mis && c == 2 + arDelay + rDelay) begin
        AXI4_M_RVALID = 1'b1;
        AXI4_M_RDATA  = rdata;
        AXI4_M_RRESP  = rresp;
      end else if (early && c <= 1 + arDelay) begin
        AXI4_M_RVALID = 1'b1;
        AXI4_M_RDATA  = ~rdata;
        AXI4_M_RRESP  = 2'd3;
      end else begin
        AXI4_M_RVALID = 1'b0;
        AXI4_M_RDATA  = 32'h0;
        AXI4_M_RRESP  = 2'd0;
      end
      nextCycle();
    end
    AXI4_M_ARREADY = 1'b0;
    AXI4_M_RVALID  = 1'b0;
  endtask

  // Linear sequence of directed steps followed by a randomized sweep.
  initial begin
    logic [31:0] rAddr;
    logic [31:0] rData;
    logic [1:0]  rSize;
    logic [1:0]  rResp;
    req_valid      = 1'b0;
    req_addr       = 32'h0;
    req_size       = 2'd0;
    req_signed     = 1'b0;
    AXI4_M_ARREADY = 1'b0;
    AXI4_M_RDATA   = 32'h0;
    AXI4_M_RRESP   = 2'd0;
    AXI4_M_RVALID  = 1'b0;

    #2 rstn = 1'b0;
    #1;
    checkOutput("reset.handshake", {28'd0, req_ready, AXI4_M_ARVALID, AXI4_M_RREADY, resp_valid}, 32'd0);
    checkOutput("reset.err", {31'd0, resp_err}, 32'd0);
    checkOutput("reset.data", resp_data, 32'd0);
    checkOutput("reset.araddr", AXI4_M_ARADDR, 32'd0);
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("reset.readyAfterRelease", {31'd0, req_ready}, 32'd1);

    applyStimulus("wordClint", 32'h0200_BFF8, 2'd2, 1'b0, 32'h8765_4321, 2'd0, 0, 0, 1'b0);
    applyStimulus("byteSigned", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_FFFF, 2'd0, 0, 0, 1'b0);
    applyStimulus("byteUnsigned", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FFFF, 2'd0, 0, 0, 1'b0);
    applyStimulus("halfMisaligned", 32'h8000_0001, 2'd1, 1'b1, 32'hFFFF_FFFF, 2'd0, 0, 0, 1'b1);
    applyStimulus("slowSlave", 32'h8000_0104, 2'd2, 1'b0, 32'hCAFE_F00D, 2'd0, 3, 2, 1'b1);
    applyStimulus("slverr", 32'h8000_0200, 2'd2, 1'b0, 32'h1234_5678, 2'd2, 0, 0, 1'b0);
    applyStimulus("afterErr", 32'h8000_0206, 2'd1, 1'b1, 32'h8001_7FFF, 2'd0, 1, 0, 1'b0);

    waitReady("abort");
    req_valid      = 1'b1;
    req_addr       = 32'h8000_0010;
    req_size       = 2'd2;
    req_signed     = 1'b0;
    AXI4_M_ARREADY = 1'b1;
    AXI4_M_RVALID  = 1'b0;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("abort.arvalid", {31'd0, AXI4_M_ARVALID}, 32'd1);
    nextCycle();
    checkOutput("abort.rreadyBefore", {31'd0, AXI4_M_RREADY}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("abort.asyncClear", {28'd0, req_ready, AXI4_M_ARVALID, AXI4_M_RREADY, resp_valid}, 32'd0);
    AXI4_M_RVALID = 1'b1;
    AXI4_M_RDATA  = 32'hDEAD_BEEF;
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput($sformatf("abort.noResp.c%0d", i), {29'd0, AXI4_M_ARVALID, AXI4_M_RREADY, resp_valid}, 32'd0);
    end
    AXI4_M_RVALID  = 1'b0;
    AXI4_M_ARREADY = 1'b0;
    applyStimulus("afterAbort", 32'h8000_0010, 2'd2, 1'b0, 32'h0BAD_CAFE, 2'd0, 0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      rAddr = $urandom;
      rData = $urandom;
      rSize = 2'($urandom_range(0, 3));
      rResp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      applyStimulus($sformatf("rand%0d", t), rAddr, rSize, 1'($urandom_range(0, 1)), rData, rResp,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24070003_axil_rd_master.md
# ysyx_24070003_axil_rd_master

AXI-Lite read initiator for the load path. Accepts one load request at a time from the core's LSU and issues a single AXI-Lite read on the AR/R channels, e.g. to the CLINT or the SRAM read port. It then returns byte-, half- or word-aligned, sign- or zero-extended data to the core. Misaligned requests are rejected locally and never issue a bus transaction.

## Interface
- ADDR_WIDTH, 32, AXI and request address width
- DATA_WIDTH, 32, AXI read data width; only 32 is supported
- clock  in  1  single clock; all state updates on posedge
- rstn  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  load request from LSU
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as misaligned
- req_signed  in  1  1 = sign-extend, 0 = zero-extend
- resp_valid  out  1  one-cycle pulse; the LSU always accepts it
- resp_data  out  DATA_WIDTH  extended load result
- resp_err  out  1  bus error or misaligned access; valid with resp_valid
- AXI4_M_ARADDR  out  ADDR_WIDTH  word-aligned read address (bits [1:0] forced to 0)
- AXI4_M_ARVALID  out  1  address valid
- AXI4_M_ARREADY  in  1  slave address ready
- AXI4_M_RDATA  in  DATA_WIDTH  read data
- AXI4_M_RRESP  in  2  read response
- AXI4_M_RVALID  in  1  read data valid
- AXI4_M_RREADY  out  1  master data ready

## Operation
- States: IDLE, AR, R, RESP.
- IDLE
  - req_ready = 1. On req_valid, latch addr, size and signed.
  - If misaligned (half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 3): go to RESP with err = 1 and data = 0.
  - Otherwise go to AR.
- AR: ARVALID = 1. ARADDR is held stable until ARVALID & ARREADY, then go to R. ARVALID never drops before the handshake.
- R
  - RREADY = 1. On RVALID, latch RDATA and set err = (RRESP ≠ 0), then go to RESP.
  - RVALID is ignored outside R. This matters for slaves that tie RVALID high.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Extraction
  - Shift RDATA right by 8 × addr[1:0].
  - Byte: take [7:0] and extend to 32 bits.
  - Half: take [15:0] and extend.
  - Word: pass through.
  - Extension is sign when req_signed = 1, zero otherwise.
- On a bus error, resp_data still carries the extracted data and resp_err = 1.
- No outstanding transactions beyond one. No write channels.

## Timing
- Reset values: req_ready = 0 (1 from the first cycle after release, when in IDLE), ARVALID = 0, RREADY = 0, resp_valid = 0, resp_err = 0, resp_data = 0, ARADDR = 0. State is IDLE.
- Reset asserted mid-transaction returns to IDLE immediately and drops ARVALID and RREADY asynchronously. No response is produced for the aborted request.
- Minimum latency with an always-ready slave (ARREADY = RVALID = 1):
  - Request accepted at cycle 0.
  - ARVALID at cycle 1.
  - RREADY and data capture at cycle 2.
  - resp_valid at cycle 3.
- Misaligned request: resp_valid in the cycle after acceptance (latency 1).
- Each wait cycle of ARREADY or RVALID adds one cycle of latency.
- All outputs are registered or decoded from state only. No combinational path from req_* to AXI outputs.
- A request asserted during RESP is not accepted (req_ready = 0). It is accepted on the following IDLE cycle, giving a back-to-back period of 4 cycles.

## Structure
- Package ysyx_24070003_axil_pkg holds:
  - state enum (IDLE, AR, R, RESP)
  - size encodings (SZ_B = 0, SZ_H = 1, SZ_W = 2)
  - RRESP constants (OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3)
- Sub-module ysyx_24070003_load_align: combinational lane shift plus sign/zero extension, with inputs RDATA, addr[1:0], size and signed. It is shared with the future cache refill path.

## Test plan
- Always-ready slave returning 0x8765_4321, word read at 0x0200_BFF8 → ARADDR = 0x0200_BFF8, resp_valid at cycle 3, data 0x8765_4321, err 0.
- Signed byte at addr 0x...03 with RDATA = 0x80FF_FFFF → data 0xFFFF_FF80; same access unsigned → 0x0000_0080.
- Half at addr 0x...01 → no ARVALID ever asserted, resp_valid one cycle after acceptance, err 1, data 0.
- ARREADY delayed 3 cycles and RVALID delayed 2 cycles → ARVALID and ARADDR stable throughout, resp_valid at cycle 8, RVALID asserted early during AR is ignored.
- RRESP = 2 with RDATA = 0x1234_5678 on a word read → err 1, data 0x1234_5678; next request is accepted normally.
- rstn pulsed low while in R → ARVALID = RREADY = resp_valid = 0 immediately, no response emitted, fresh request after release completes with nominal latency.
